ex_stage: RTL and testbench

Execute stage of the in-order RV32IM pipeline, placed directly upstream of `mem_stage`. It takes the decoded instruction from ID and evaluates RV32I ALU operations in one cycle and RV32M multiply/divide operations iteratively. It registers the result, together with the memory and writeback control fields, into the `ex2mem_t` pipeline register that `mem_stage` consumes. It stalls ID while a multi-cycle operation runs, and it kills its slot when MEM resolves a taken branch.

---
 rtl/riscv_cpu_pkg.sv | 74 +++++++
 rtl/ex_muldiv_iter.sv | 187 ++++++++++++++++++
 rtl/ex_stage.sv | 100 ++++++++++
 tb/tb_ex_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_cpu_pkg
// Description : Shared types and constants for the RV32IM pipeline.
//               Holds the ALU operation encoding and the ID->EX and
//               EX->MEM pipeline register layouts.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_cpu_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int MULDIV_CYCLES = 32;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    // Memory / branch control carried from ID through EX into MEM
    typedef struct packed {
        logic                  mem_we;
        logic                  mem_re;
        logic [2:0]            mem_size;
        logic                  branch_mux;
        logic [DATA_WIDTH-1:0] store_data;
    } id_stage_t;

    // Writeback control carried through to WB
    typedef struct packed {
        logic       reg_we;
        logic [4:0] rd_addr;
        logic [1:0] wb_sel;
    } wb_pipeline_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] op_a;
        logic [DATA_WIDTH-1:0] op_b;
        alu_op_e               alu_op;
        id_stage_t             id_stage;
        wb_pipeline_t          wb_pipeline;
    } id2ex_t;

    typedef struct packed {
        id_stage_t             id_stage;
        logic [DATA_WIDTH-1:0] alu_result;
        wb_pipeline_t          wb_pipeline;
    } ex2mem_t;

    function automatic logic is_muldiv_op(alu_op_e op);
        case (op)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_iter
// Description : Iterative RV32M multiply/divide unit. Operates on operand
//               magnitudes (shift-add multiply, restoring divide), one bit
//               per cycle, and applies signs / special cases in DONE.
// Ports       : clk_i, rst_i   - clock, synchronous active-high reset
//               kill_i         - abandon any operation, return to IDLE
//               start_i        - op_i/a_i/b_i hold a muldiv op to start
//               done_o         - result_o is valid this cycle
//               result_o       - final 32-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_iter
    import riscv_cpu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  kill_i,
    input  logic                  start_i,
    input  alu_op_e               op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam logic [4:0] c_CNT_LAST = 5'(MULDIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    md_state_e             state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    alu_op_e               op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;     // original operands, for signs and special cases
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d; // multiplicand (mul) or divisor (div) magnitude
    logic [DATA_WIDTH-1:0] hi_q, hi_d;   // product high half / partial remainder
    logic [DATA_WIDTH-1:0] lo_q, lo_d;   // multiplier -> product low half / dividend -> quotient

    function automatic logic a_is_signed(alu_op_e op);
        return (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic b_is_signed(alu_op_e op);
        return (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_mul(alu_op_e op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

    // Start-time magnitudes
    logic                  w_a_neg_in, w_b_neg_in;
    logic [DATA_WIDTH-1:0] w_mag_a, w_mag_b;

    assign w_a_neg_in = a_is_signed(op_i) && a_i[DATA_WIDTH-1];
    assign w_b_neg_in = b_is_signed(op_i) && b_i[DATA_WIDTH-1];
    assign w_mag_a    = w_a_neg_in ? (~a_i + 1'b1) : a_i;
    assign w_mag_b    = w_b_neg_in ? (~b_i + 1'b1) : b_i;

    // One iteration of each algorithm
    logic [DATA_WIDTH:0] w_mul_sum;
    logic [DATA_WIDTH:0] w_div_shift;
    logic [DATA_WIDTH:0] w_div_trial;

    assign w_mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? dvs_q : '0)};
    assign w_div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CALC;
                    cnt_d   = c_CNT_LAST;
                    op_d    = op_i;
                    a_d     = a_i;
                    b_d     = b_i;
                    hi_d    = '0;
                    if (is_mul(op_i)) begin
                        dvs_d = w_mag_a;
                        lo_d  = w_mag_b;
                    end else begin
                        dvs_d = w_mag_b;
                        lo_d  = w_mag_a;
                    end
                end
            end
            S_CALC: begin
                if (is_mul(op_q)) begin
                    // Add-then-shift: product assembles in {hi, lo} as lo shifts out
                    hi_d = w_mul_sum[DATA_WIDTH:1];
                    lo_d = {w_mul_sum[0], lo_q[DATA_WIDTH-1:1]};
                end else if (!w_div_trial[DATA_WIDTH]) begin
                    hi_d = w_div_trial[DATA_WIDTH-1:0];
                    lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = w_div_shift[DATA_WIDTH-1:0];
                    lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
                end
                if (cnt_q == 5'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (kill_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= ALU_ADD;
            a_q     <= '0;
            b_q     <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Sign fix-up and special cases
    logic                      w_a_neg, w_b_neg, w_div_zero, w_div_ovf;
    logic [2*DATA_WIDTH-1:0]   w_prod, w_prod_s;
    logic [DATA_WIDTH-1:0]     w_quot_s, w_rem_s;

    assign w_a_neg    = a_is_signed(op_q) && a_q[DATA_WIDTH-1];
    assign w_b_neg    = b_is_signed(op_q) && b_q[DATA_WIDTH-1];
    assign w_div_zero = (b_q == '0);
    assign w_div_ovf  = (a_q == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (b_q == '1);
    assign w_prod     = {hi_q, lo_q};
    assign w_prod_s   = (w_a_neg ^ w_b_neg) ? (~w_prod + 1'b1) : w_prod;
    assign w_quot_s   = (w_a_neg ^ w_b_neg) ? (~lo_q + 1'b1) : lo_q;
    assign w_rem_s    = w_a_neg ? (~hi_q + 1'b1) : hi_q;

    always_comb begin
        result_o = '0;
        case (op_q)
            ALU_MUL:                         result_o = w_prod[DATA_WIDTH-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: result_o = w_prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            ALU_DIV:  result_o = w_div_zero ? '1 : (w_div_ovf ? a_q : w_quot_s);
            ALU_DIVU: result_o = w_div_zero ? '1 : lo_q;
            ALU_REM:  result_o = w_div_zero ? a_q : (w_div_ovf ? '0 : w_rem_s);
            ALU_REMU: result_o = w_div_zero ? a_q : hi_q;
            default:  result_o = '0;
        endcase
    end

    assign done_o = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage of the in-order RV32IM pipeline. Single-cycle
//               RV32I ALU plus iterative RV32M unit, feeding the EX->MEM
//               pipeline register.
// Ports       : clk_i, rst_i    - clock, synchronous active-high reset
//               ex_pipeline_i   - decoded instruction from ID
//               ex_valid_i      - ex_pipeline_i is live
//               ex_ready_o      - instruction consumed this cycle
//               flush_i         - taken branch in MEM, kill EX slot
//               mem_pipeline_o  - registered EX->MEM fields
//               mem_valid_o     - mem_pipeline_o is live
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import riscv_cpu_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  id2ex_t  ex_pipeline_i,
    input  logic    ex_valid_i,
    output logic    ex_ready_o,
    input  logic    flush_i,
    output ex2mem_t mem_pipeline_o,
    output logic    mem_valid_o
);

    logic [DATA_WIDTH-1:0] w_op_a, w_op_b, w_alu_res, w_md_res, w_result;
    logic [4:0]            w_shamt;
    logic                  w_is_md, w_md_done;

    ex2mem_t mem_pipeline_q, mem_pipeline_d;
    logic    mem_valid_q, mem_valid_d;

    assign w_op_a  = ex_pipeline_i.op_a;
    assign w_op_b  = ex_pipeline_i.op_b;
    assign w_shamt = w_op_b[4:0];
    assign w_is_md = is_muldiv_op(ex_pipeline_i.alu_op);

    always_comb begin
        w_alu_res = '0;
        case (ex_pipeline_i.alu_op)
            ALU_ADD:  w_alu_res = w_op_a + w_op_b;
            ALU_SUB:  w_alu_res = w_op_a - w_op_b;
            ALU_AND:  w_alu_res = w_op_a & w_op_b;
            ALU_OR:   w_alu_res = w_op_a | w_op_b;
            ALU_XOR:  w_alu_res = w_op_a ^ w_op_b;
            ALU_SLL:  w_alu_res = w_op_a << w_shamt;
            ALU_SRL:  w_alu_res = w_op_a >> w_shamt;
            ALU_SRA:  w_alu_res = $unsigned($signed(w_op_a) >>> w_shamt);
            ALU_SLT:  w_alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            ALU_SLTU: w_alu_res = {{(DATA_WIDTH-1){1'b0}}, (w_op_a < w_op_b)};
            default:  w_alu_res = '0;
        endcase
    end

    // The unit only starts from IDLE, so holding start high while ID waits
    // for ready does not retrigger it mid-operation.
    ex_muldiv_iter u_muldiv (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .kill_i   (flush_i),
        .start_i  (ex_valid_i && w_is_md),
        .op_i     (ex_pipeline_i.alu_op),
        .a_i      (w_op_a),
        .b_i      (w_op_b),
        .done_o   (w_md_done),
        .result_o (w_md_res)
    );

    assign ex_ready_o = !(ex_valid_i && w_is_md && !w_md_done);
    assign w_result   = w_is_md ? w_md_res : w_alu_res;

    always_comb begin
        mem_pipeline_d = '0;
        mem_valid_d    = 1'b0;
        if (!flush_i && ex_valid_i && ex_ready_o) begin
            mem_pipeline_d.id_stage    = ex_pipeline_i.id_stage;
            mem_pipeline_d.alu_result  = w_result;
            mem_pipeline_d.wb_pipeline = ex_pipeline_i.wb_pipeline;
            mem_valid_d                = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_pipeline_q <= '0;
            mem_valid_q    <= 1'b0;
        end else begin
            mem_pipeline_q <= mem_pipeline_d;
            mem_valid_q    <= mem_valid_d;
        end
    end

    assign mem_pipeline_o = mem_pipeline_q;
    assign mem_valid_o    = mem_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage with a behavioural model
//               built on plain 64-bit arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
    import riscv_cpu_pkg::*;

    logic    clk;
    logic    rst_i;
    id2ex_t  ex_pipeline_i;
    logic    ex_valid_i;
    logic    ex_ready_o;
    logic    flush_i;
    ex2mem_t mem_pipeline_o;
    logic    mem_valid_o;

    int n_total = 0;
    int n_pass  = 0;

    logic        mon_en = 1'b0;
    logic [31:0] mon_q[$];

    ex_stage dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .ex_pipeline_i  (ex_pipeline_i),
        .ex_valid_i     (ex_valid_i),
        .ex_ready_o     (ex_ready_o),
        .flush_i        (flush_i),
        .mem_pipeline_o (mem_pipeline_o),
        .mem_valid_o    (mem_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && mem_valid_o) mon_q.push_back(mem_pipeline_o.alu_result);
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_op(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_XOR:    return a ^ b;
            ALU_SLL:    return a << b[4:0];
            ALU_SRL:    return a >> b[4:0];
            ALU_SRA:    return $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:    return (ia < ib) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            ALU_MUL:    begin p = sa * sb; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            ALU_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            ALU_REMU:   return (b == 32'd0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the capture edge
    // with ex_valid_i already dropped.
    task automatic do_op(input alu_op_e op, input logic [31:0] a, input logic [31:0] b, input string tag);
        id2ex_t      ins;
        logic [63:0] r;
        logic [31:0] exp;
        int          cyc;
        logic        bub_ok;
        r = {$urandom, $urandom};
        ins.op_a        = a;
        ins.op_b        = b;
        ins.alu_op      = op;
        ins.id_stage    = r[37:0];
        ins.wb_pipeline = r[45:38];
        exp             = ref_op(op, a, b);
        ex_pipeline_i   = ins;
        ex_valid_i      = 1'b1;
        #1;
        cyc    = 0;
        bub_ok = 1'b1;
        while (!ex_ready_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_valid_o) bub_ok = 1'b0;
        end
        chk({tag, " stall"}, 96'(cyc), is_muldiv_op(op) ? 96'd33 : 96'd0);
        chk({tag, " bubble"}, 96'(bub_ok), 96'd1);
        @(negedge clk);
        ex_valid_i = 1'b0;
        chk({tag, " valid"}, 96'(mem_valid_o), 96'd1);
        chk({tag, " result"}, 96'(mem_pipeline_o.alu_result), 96'(exp));
        chk({tag, " id_stage"}, 96'(mem_pipeline_o.id_stage), 96'(ins.id_stage));
        chk({tag, " wb"}, 96'(mem_pipeline_o.wb_pipeline), 96'(ins.wb_pipeline));
    endtask

    task automatic drive_raw(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        ex_pipeline_i        = '0;
        ex_pipeline_i.op_a   = a;
        ex_pipeline_i.op_b   = b;
        ex_pipeline_i.alu_op = op;
        ex_pipeline_i.id_stage.mem_we = 1'b1;
        ex_valid_i           = 1'b1;
    endtask

    initial begin
        int cyc;
        rst_i         = 1'b1;
        ex_valid_i    = 1'b0;
        flush_i       = 1'b0;
        ex_pipeline_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset valid", 96'(mem_valid_o), 96'd0);
        chk("reset pipe", 96'(mem_pipeline_o), 96'd0);
        chk("reset ready", 96'(ex_ready_o), 96'd1);
        rst_i = 1'b0;
        @(negedge clk);

        // Directed ALU / muldiv cases
        do_op(ALU_ADD, 32'd5, 32'hFFFF_FFFF, "add_wrap");
        chk("add_wrap literal", 96'(mem_pipeline_o.alu_result), 96'd4);
        do_op(ALU_SRA, 32'h8000_0000, 32'd31, "sra");
        chk("sra literal", 96'(mem_pipeline_o.alu_result), 96'hFFFF_FFFF);
        do_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ff");
        chk("mul_ff literal", 96'(mem_pipeline_o.alu_result), 96'd1);
        do_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff");
        chk("mulhu_ff literal", 96'(mem_pipeline_o.alu_result), 96'hFFFF_FFFE);
        do_op(ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ff");
        do_op(ALU_DIV, 32'd7, 32'd0, "div_by0");
        do_op(ALU_REMU, 32'd7, 32'd0, "remu_by0");
        do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        do_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, "rem_neg");
        chk("rem_neg literal", 96'(mem_pipeline_o.alu_result), 96'hFFFF_FFFF);
        do_op(ALU_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "mulhsu");

        // Flush mid-CALC
        drive_raw(ALU_DIVU, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i    = 1'b0;
        ex_valid_i = 1'b0;
        chk("flush calc valid", 96'(mem_valid_o), 96'd0);
        chk("flush calc pipe", 96'(mem_pipeline_o), 96'd0);
        do_op(ALU_SUB, 32'd3, 32'd10, "after_flush");

        // Reset mid-CALC
        drive_raw(ALU_MUL, 32'd9, 32'd9);
        repeat (6) @(negedge clk);
        rst_i      = 1'b1;
        ex_valid_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        chk("rst calc valid", 96'(mem_valid_o), 96'd0);
        chk("rst calc pipe", 96'(mem_pipeline_o), 96'd0);
        do_op(ALU_MUL, 32'd3, 32'd4, "mul_after_rst");
        chk("mul_after_rst literal", 96'(mem_pipeline_o.alu_result), 96'd12);

        // Flush coinciding with DONE drops the muldiv
        drive_raw(ALU_MUL, 32'd6, 32'd7);
        #1;
        cyc = 0;
        while (!ex_ready_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("flush_done reach", 96'(cyc), 96'd33);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i    = 1'b0;
        ex_valid_i = 1'b0;
        chk("flush_done valid", 96'(mem_valid_o), 96'd0);
        @(negedge clk);
        chk("flush_done late", 96'(mem_valid_o), 96'd0);

        // ALU capture with flush is a bubble
        drive_raw(ALU_OR, 32'd1, 32'd2);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i    = 1'b0;
        ex_valid_i = 1'b0;
        chk("flush_alu valid", 96'(mem_valid_o), 96'd0);

        // ADD, MUL, ADD stream: exactly three outputs in order
        #2;
        mon_q.delete();
        mon_en = 1'b1;
        @(negedge clk);
        do_op(ALU_ADD, 32'd10, 32'd20, "s_add1");
        do_op(ALU_MUL, 32'd123, 32'd456, "s_mul");
        do_op(ALU_ADD, 32'd7, 32'd8, "s_add2");
        repeat (3) @(negedge clk);
        #2;
        mon_en = 1'b0;
        chk("stream count", 96'(mon_q.size()), 96'd3);
        if (mon_q.size() == 3) begin
            chk("stream 0", 96'(mon_q[0]), 96'd30);
            chk("stream 1", 96'(mon_q[1]), 96'd56088);
            chk("stream 2", 96'(mon_q[2]), 96'd15);
        end
        @(negedge clk);

        // Randomized back-to-back ALU ops
        for (int i = 0; i < 24; i++) begin
            do_op(alu_op_e'(5'($urandom_range(0, 9))), $urandom, $urandom, "rnd_alu");
        end

        // Randomized muldiv ops, with zero divisors and sign corners mixed in
        for (int i = 0; i < 12; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            do_op(alu_op_e'(5'($urandom_range(10, 17))), ra, rb, "rnd_md");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
